// File: rtl/rat_ckpt.sv
`timescale 1ns/1ps
// rat_ckpt: superscalar register alias table with checkpoint-based branch
// recovery.
//
// It renames up to DISPATCH_WIDTH instructions per cycle. Lane 0 is the
// oldest lane, and results from older lanes in the same group bypass to
// younger lanes. Readiness of each architectural register is tracked from
// CDB_PORTS writeback buses.
//
// Branches capture map snapshots into NUM_CKPT circular slots. A mispredict
// restores the map from the branch's slot in one cycle. A flush restores the
// map from the retirement RAT.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   disp_valid/rd/rs1/rs2/we/pd/ckpt   per-lane dispatch group
//   ps1/ps2, ps1_valid/ps2_valid   combinational renamed sources + readiness
//   disp_ready                     group accepted this cycle
//   ckpt_id                        slot a checkpointing lane receives (tail)
//   cdb_valid/rd/pd                per-port writeback broadcast
//   br_resolve/br_id/br_mispredict branch resolution
//   flush, rrat                    global flush to the retirement map
//   ckpt_count                     occupied snapshot slots
module rat_ckpt #(
    parameter int ARCH_REGS      = 32,
    parameter int PHYS_REG_BITS  = 6,
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_PORTS      = 5,
    parameter int NUM_CKPT       = 4,
    localparam int AREG_BITS     = $clog2(ARCH_REGS),
    localparam int CKPT_BITS     = $clog2(NUM_CKPT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_valid [DISPATCH_WIDTH],
    input  logic [AREG_BITS-1:0]     disp_rd    [DISPATCH_WIDTH],
    input  logic [AREG_BITS-1:0]     disp_rs1   [DISPATCH_WIDTH],
    input  logic [AREG_BITS-1:0]     disp_rs2   [DISPATCH_WIDTH],
    input  logic                     disp_we    [DISPATCH_WIDTH],
    input  logic [PHYS_REG_BITS-1:0] disp_pd    [DISPATCH_WIDTH],
    input  logic                     disp_ckpt  [DISPATCH_WIDTH],
    output logic [PHYS_REG_BITS-1:0] ps1        [DISPATCH_WIDTH],
    output logic [PHYS_REG_BITS-1:0] ps2        [DISPATCH_WIDTH],
    output logic                     ps1_valid  [DISPATCH_WIDTH],
    output logic                     ps2_valid  [DISPATCH_WIDTH],
    output logic                     disp_ready,
    output logic [CKPT_BITS-1:0]     ckpt_id,
    input  logic                     cdb_valid  [CDB_PORTS],
    input  logic [AREG_BITS-1:0]     cdb_rd     [CDB_PORTS],
    input  logic [PHYS_REG_BITS-1:0] cdb_pd     [CDB_PORTS],
    input  logic                     br_resolve,
    input  logic [CKPT_BITS-1:0]     br_id,
    input  logic                     br_mispredict,
    input  logic                     flush,
    input  logic [PHYS_REG_BITS-1:0] rrat       [ARCH_REGS],
    output logic [CKPT_BITS:0]       ckpt_count
);

    localparam logic [CKPT_BITS:0] FULL = (CKPT_BITS+1)'(NUM_CKPT);

    logic [PHYS_REG_BITS-1:0] map [ARCH_REGS];
    logic [ARCH_REGS-1:0]     ready;
    logic [PHYS_REG_BITS-1:0] snap_map [NUM_CKPT][ARCH_REGS];
    logic [ARCH_REGS-1:0]     snap_ready [NUM_CKPT];
    logic [CKPT_BITS-1:0]     head, tail;
    logic [CKPT_BITS:0]       count;
    logic [NUM_CKPT-1:0]      done;

    logic                     mispredict, any_ckpt, accept, alloc, retire;
    logic [NUM_CKPT-1:0]      done_eff;
    logic [PHYS_REG_BITS-1:0] map_n [ARCH_REGS];
    logic [PHYS_REG_BITS-1:0] snap_map_n [ARCH_REGS];
    logic [ARCH_REGS-1:0]     ready_n, snap_ready_n, rest_ready;

    assign mispredict = br_resolve && br_mispredict;
    assign ckpt_id    = tail;
    assign ckpt_count = count;

    // Source lookup: table value first, then the youngest older lane in the
    // group that writes the same register overrides it; x0 is always ready.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            ps1[k]       = map[disp_rs1[k]];
            ps1_valid[k] = ready[disp_rs1[k]];
            ps2[k]       = map[disp_rs2[k]];
            ps2_valid[k] = ready[disp_rs2[k]];
            for (int j = 0; j < k; j++) begin
                if (disp_valid[j] && disp_we[j] && disp_rd[j] != '0) begin
                    if (disp_rd[j] == disp_rs1[k]) begin
                        ps1[k]       = disp_pd[j];
                        ps1_valid[k] = 1'b0;
                    end
                    if (disp_rd[j] == disp_rs2[k]) begin
                        ps2[k]       = disp_pd[j];
                        ps2_valid[k] = 1'b0;
                    end
                end
            end
            if (disp_rs1[k] == '0) begin
                ps1[k]       = map[0];
                ps1_valid[k] = 1'b1;
            end
            if (disp_rs2[k] == '0) begin
                ps2[k]       = map[0];
                ps2_valid[k] = 1'b1;
            end
        end
    end

    always_comb begin
        any_ckpt = 1'b0;
        for (int k = 0; k < DISPATCH_WIDTH; k++)
            any_ckpt = any_ckpt | (disp_valid[k] & disp_ckpt[k]);
    end

    assign disp_ready = !(any_ckpt && count == FULL);
    assign accept     = disp_ready && !flush && !mispredict;

    // Next live state and the snapshot to capture. CDB matches are taken
    // against the pre-dispatch map, and dispatch writes then override them,
    // so a same-cycle rename of the register keeps it not-ready.
    always_comb begin
        map_n        = map;
        ready_n      = ready;
        snap_map_n   = map;
        snap_ready_n = ready;
        rest_ready   = snap_ready[br_id];
        alloc        = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
                if (map[cdb_rd[p]] == cdb_pd[p])
                    ready_n[cdb_rd[p]] = 1'b1;
                if (snap_map[br_id][cdb_rd[p]] == cdb_pd[p])
                    rest_ready[cdb_rd[p]] = 1'b1;
            end
        end
        if (accept) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (disp_valid[k] && disp_we[k] && disp_rd[k] != '0) begin
                    map_n[disp_rd[k]]   = disp_pd[k];
                    ready_n[disp_rd[k]] = 1'b0;
                end
                // The snapshot covers lanes up to and including the branch lane.
                if (disp_valid[k] && disp_ckpt[k]) begin
                    alloc        = 1'b1;
                    snap_map_n   = map_n;
                    snap_ready_n = ready_n;
                end
            end
        end
        ready_n[0]    = 1'b1;
        rest_ready[0] = 1'b1;
    end

    // A resolve of the head slot in this cycle retires it immediately.
    always_comb begin
        done_eff = done;
        if (br_resolve && !br_mispredict)
            done_eff[br_id] = 1'b1;
        retire = (count != '0) && done_eff[head];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                map[i] <= PHYS_REG_BITS'(i);
            ready <= '1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else if (flush) begin
            map   <= rrat;
            ready <= '1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else if (mispredict) begin
            map   <= snap_map[br_id];
            ready <= rest_ready;
            tail  <= br_id + CKPT_BITS'(1);
            // The branch slot is still occupied, so the count is never zero.
            count <= {1'b0, br_id - head} + (CKPT_BITS+1)'(1);
        end else begin
            logic [NUM_CKPT-1:0] done_n;
            done_n = done_eff;
            map    <= map_n;
            ready  <= ready_n;
            if (retire) begin
                done_n[head] = 1'b0;
                head <= head + CKPT_BITS'(1);
            end
            if (alloc) begin
                done_n[tail] = 1'b0;
                tail <= tail + CKPT_BITS'(1);
            end
            done  <= done_n;
            count <= count + {{CKPT_BITS{1'b0}}, alloc} - {{CKPT_BITS{1'b0}}, retire};
        end
    end

    // Snapshot storage holds data only. Every slot tracks CDB readiness, and
    // a newly allocated slot is overwritten with its fresh capture.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_CKPT; s++)
            for (int p = 0; p < CDB_PORTS; p++)
                if (cdb_valid[p] && snap_map[s][cdb_rd[p]] == cdb_pd[p])
                    snap_ready[s][cdb_rd[p]] <= 1'b1;
        if (alloc) begin
            snap_map[tail]   <= snap_map_n;
            snap_ready[tail] <= snap_ready_n;
        end
    end

endmodule

// File: tb/tb_rat_ckpt.sv
`timescale 1ns/1ps
// Directed bench for rat_ckpt: renaming, intra-group bypass, CDB wakeup,
// checkpoint capture/restore, slot-full backpressure, in-order slot
// retirement, flush and asynchronous reset.
module tb_rat_ckpt;

    localparam int DW = 2;
    localparam int CP = 5;

    logic       clk, rst;
    logic       disp_valid [DW];
    logic [4:0] disp_rd [DW], disp_rs1 [DW], disp_rs2 [DW];
    logic       disp_we [DW];
    logic [5:0] disp_pd [DW];
    logic       disp_ckpt [DW];
    logic [5:0] ps1 [DW], ps2 [DW];
    logic       ps1_valid [DW], ps2_valid [DW];
    logic       disp_ready;
    logic [1:0] ckpt_id;
    logic       cdb_valid [CP];
    logic [4:0] cdb_rd [CP];
    logic [5:0] cdb_pd [CP];
    logic       br_resolve, br_mispredict, flush;
    logic [1:0] br_id;
    logic [5:0] rrat [32];
    logic [2:0] ckpt_count;

    int checks = 0;
    int errors = 0;

    rat_ckpt dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_rs1(disp_rs1),
        .disp_rs2(disp_rs2), .disp_we(disp_we), .disp_pd(disp_pd),
        .disp_ckpt(disp_ckpt), .ps1(ps1), .ps2(ps2),
        .ps1_valid(ps1_valid), .ps2_valid(ps2_valid),
        .disp_ready(disp_ready), .ckpt_id(ckpt_id),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_pd(cdb_pd),
        .br_resolve(br_resolve), .br_id(br_id), .br_mispredict(br_mispredict),
        .flush(flush), .rrat(rrat), .ckpt_count(ckpt_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < DW; k++) begin
            disp_valid[k] = 1'b0; disp_we[k] = 1'b0; disp_ckpt[k] = 1'b0;
            disp_rd[k] = '0; disp_rs1[k] = '0; disp_rs2[k] = '0; disp_pd[k] = '0;
        end
        for (int p = 0; p < CP; p++) begin
            cdb_valid[p] = 1'b0; cdb_rd[p] = '0; cdb_pd[p] = '0;
        end
        br_resolve = 1'b0; br_mispredict = 1'b0; br_id = '0; flush = 1'b0;
    endtask

    task automatic lane(input int k, input logic we, input logic [4:0] rd,
                        input logic [5:0] pd, input logic ck);
        disp_valid[k] = 1'b1; disp_we[k] = we; disp_rd[k] = rd;
        disp_pd[k] = pd; disp_ckpt[k] = ck;
    endtask

    // Reads the table through lane 0's rs1 lookup; lane 0 has no older lanes.
    task automatic peek(input string tag, input logic [4:0] r,
                        input logic [5:0] eps, input logic ev);
        disp_rs1[0] = r;
        #1;
        chk({tag, "_ps"}, 32'(ps1[0]), 32'(eps));
        chk({tag, "_v"}, 32'(ps1_valid[0]), 32'(ev));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) rrat[i] = 6'(i + 32);
        tick(); tick();
        rst = 1'b1;
        #1;

        // Reset state and identity lookup
        chk("rst_ckpt_id", 32'(ckpt_id), 0);
        chk("rst_count", 32'(ckpt_count), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        disp_rs1[0] = 5'd5; disp_rs2[0] = 5'd7;
        #1;
        chk("rst_ps1", 32'(ps1[0]), 5);
        chk("rst_ps1_v", 32'(ps1_valid[0]), 1);
        chk("rst_ps2", 32'(ps2[0]), 7);
        chk("rst_ps2_v", 32'(ps2_valid[0]), 1);

        // Rename x5 -> 40, then wake it via CDB
        lane(0, 1'b1, 5'd5, 6'd40, 1'b0);
        tick(); idle();
        peek("x5_renamed", 5'd5, 6'd40, 1'b0);
        cdb_valid[0] = 1'b1; cdb_rd[0] = 5'd5; cdb_pd[0] = 6'd40;
        peek("x5_no_bypass", 5'd5, 6'd40, 1'b0);
        tick(); idle();
        peek("x5_woken", 5'd5, 6'd40, 1'b1);

        // Intra-group bypass and same-rd younger-wins
        lane(0, 1'b1, 5'd3, 6'd33, 1'b0);
        lane(1, 1'b1, 5'd3, 6'd34, 1'b0);
        disp_rs1[1] = 5'd3; disp_rs2[1] = 5'd5;
        #1;
        chk("byp_ps1", 32'(ps1[1]), 33);
        chk("byp_ps1_v", 32'(ps1_valid[1]), 0);
        chk("byp_ps2", 32'(ps2[1]), 40);
        chk("byp_ps2_v", 32'(ps2_valid[1]), 1);
        tick(); idle();
        peek("x3_younger", 5'd3, 6'd34, 1'b0);

        // rd = 0 is never renamed nor bypassed
        lane(0, 1'b1, 5'd0, 6'd60, 1'b0);
        disp_valid[1] = 1'b1; disp_rs1[1] = 5'd0;
        #1;
        chk("x0_byp_ps", 32'(ps1[1]), 0);
        chk("x0_byp_v", 32'(ps1_valid[1]), 1);
        tick(); idle();
        peek("x0_map", 5'd0, 6'd0, 1'b1);

        // Branch on lane 0, x8 renamed on lane 1, then mispredict id 0
        lane(0, 1'b0, 5'd0, 6'd0, 1'b1);
        lane(1, 1'b1, 5'd8, 6'd50, 1'b0);
        #1;
        chk("br0_ckpt_id", 32'(ckpt_id), 0);
        chk("br0_ready", 32'(disp_ready), 1);
        tick(); idle();
        chk("br0_count", 32'(ckpt_count), 1);
        peek("x8_renamed", 5'd8, 6'd50, 1'b0);
        br_resolve = 1'b1; br_mispredict = 1'b1; br_id = 2'd0;
        lane(0, 1'b1, 5'd9, 6'd51, 1'b0);
        tick(); idle();
        peek("x8_restored", 5'd8, 6'd8, 1'b1);
        peek("x9_dropped", 5'd9, 6'd9, 1'b1);
        peek("x3_in_snap", 5'd3, 6'd34, 1'b0);
        chk("mp0_tail", 32'(ckpt_id), 1);
        chk("mp0_count", 32'(ckpt_count), 1);

        // Stale CDB: snapshot slot 1 holds x3 -> 33, live map moves to 34
        lane(0, 1'b1, 5'd3, 6'd33, 1'b0);
        lane(1, 1'b0, 5'd0, 6'd0, 1'b1);
        #1;
        chk("br1_ckpt_id", 32'(ckpt_id), 1);
        tick(); idle();
        lane(0, 1'b1, 5'd3, 6'd34, 1'b0);
        tick(); idle();
        cdb_valid[2] = 1'b1; cdb_rd[2] = 5'd3; cdb_pd[2] = 6'd33;
        tick(); idle();
        peek("stale_live", 5'd3, 6'd34, 1'b0);
        br_resolve = 1'b1; br_mispredict = 1'b1; br_id = 2'd1;
        tick(); idle();
        peek("stale_snap", 5'd3, 6'd33, 1'b1);
        chk("mp1_tail", 32'(ckpt_id), 2);
        chk("mp1_count", 32'(ckpt_count), 2);

        // Fill slots 2 and 3, then a fifth request stalls
        lane(0, 1'b0, 5'd0, 6'd0, 1'b1);
        tick(); idle();
        lane(0, 1'b0, 5'd0, 6'd0, 1'b1);
        tick(); idle();
        chk("full_count", 32'(ckpt_count), 4);
        lane(0, 1'b0, 5'd0, 6'd0, 1'b1);
        lane(1, 1'b1, 5'd10, 6'd55, 1'b0);
        #1;
        chk("full_ready", 32'(disp_ready), 0);
        tick(); idle();
        peek("full_no_write", 5'd10, 6'd10, 1'b1);
        chk("full_count_hold", 32'(ckpt_count), 4);
        chk("full_tail_hold", 32'(ckpt_id), 0);

        // Out-of-order correct resolves retire in order
        br_resolve = 1'b1; br_id = 2'd1;
        tick(); idle();
        chk("res1_count", 32'(ckpt_count), 4);
        br_resolve = 1'b1; br_id = 2'd0;
        tick(); idle();
        chk("res0_count", 32'(ckpt_count), 3);
        disp_valid[0] = 1'b1; disp_ckpt[0] = 1'b1;
        #1;
        chk("notfull_ready", 32'(disp_ready), 1);
        idle();
        tick();
        chk("res_chain_count", 32'(ckpt_count), 2);

        // Flush beats a same-cycle mispredict and dispatch
        flush = 1'b1; br_resolve = 1'b1; br_mispredict = 1'b1; br_id = 2'd2;
        lane(0, 1'b1, 5'd11, 6'd56, 1'b0);
        tick(); idle();
        peek("flush_x11", 5'd11, 6'd43, 1'b1);
        peek("flush_x3", 5'd3, 6'd35, 1'b1);
        peek("flush_x0", 5'd0, 6'd32, 1'b1);
        chk("flush_count", 32'(ckpt_count), 0);
        chk("flush_tail", 32'(ckpt_id), 0);

        // Asynchronous reset mid-stream
        lane(0, 1'b1, 5'd12, 6'd57, 1'b0);
        lane(1, 1'b0, 5'd0, 6'd0, 1'b1);
        tick(); idle();
        peek("pre_rst_x12", 5'd12, 6'd57, 1'b0);
        chk("pre_rst_count", 32'(ckpt_count), 1);
        #2 rst = 1'b0;
        peek("arst_x12", 5'd12, 6'd12, 1'b1);
        chk("arst_count", 32'(ckpt_count), 0);
        chk("arst_tail", 32'(ckpt_id), 0);
        #2 rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
